// File: rtl/sha2_compress_engine_pkg.sv
// Constants, types and bit helpers shared by the SHA-2 compression engine.
package sha2_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   // Groups of three: big sigma0, big sigma1, small sigma0, small sigma1 (last of small is a shift)
   localparam int ROT512 [12] = '{28, 34, 39, 14, 18, 41, 1, 8, 7, 19, 61, 6};
   localparam int ROT256 [12] = '{2, 13, 22, 6, 11, 25, 7, 18, 3, 17, 19, 10};

   localparam logic [63:0] K512 [80] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
   };

   localparam logic [31:0] K256 [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Rotate right within a w-bit word carried in the low bits of a 64-bit container.
   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
      logic [63:0] m;
      logic [63:0] xm;
      m  = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      xm = x & m;
      return ((xm >> n) | (xm << (w - n))) & m;
   endfunction

   function automatic logic [63:0] shr(input logic [63:0] x, input int n);
      return x >> n;
   endfunction

   function automatic int rot_amt(input int w, input logic [3:0] i);
      return (w == 64) ? ROT512[i] : ROT256[i];
   endfunction

   function automatic logic [63:0] sigma(input logic [63:0] x, input int w, input logic [3:0] base,
                                         input logic is_small);
      logic [63:0] r;
      r = rotr(x, rot_amt(w, base), w) ^ rotr(x, rot_amt(w, base + 4'd1), w);
      if (is_small) r = r ^ shr(x, rot_amt(w, base + 4'd2));
      else          r = r ^ rotr(x, rot_amt(w, base + 4'd2), w);
      return r;
   endfunction

endpackage

// File: rtl/sha2_compress_engine_round.sv
// One combinational SHA-2 round; working variables packed a (MS) .. h (LS).
module sha2_round
   import sha2_pkg::*;
#(
   parameter int WORD = 64
) (
   input  logic [8*WORD-1:0] st_i,
   input  logic [WORD-1:0]   wt_i,
   input  logic [WORD-1:0]   kt_i,
   output logic [8*WORD-1:0] st_o
);
   logic [WORD-1:0] a, b, c, d, e, f, g, h;
   logic [WORD-1:0] bs0, bs1, ch, maj, t1, t2;

   assign {a, b, c, d, e, f, g, h} = st_i;

   assign bs0 = WORD'(sigma(64'(a), WORD, 4'd0, 1'b0));
   assign bs1 = WORD'(sigma(64'(e), WORD, 4'd3, 1'b0));
   assign ch  = (e & f) ^ (~e & g);
   assign maj = (a & b) ^ (a & c) ^ (b & c);
   assign t1  = h + bs1 + ch + kt_i + wt_i;
   assign t2  = bs0 + maj;

   assign st_o = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_compress_engine.sv
// Iterative SHA-2 compression: UNROLL chained rounds per clock with a sliding
// 16-word message schedule window.
//
//   state | meaning
//   IDLE  | waiting for a block, in_ready high
//   RUN   | applying rounds, schedule window advancing
//   DONE  | out_hash valid, held until out_ready
module sha2_compress_engine
   import sha2_pkg::*;
#(
   parameter int WORD   = 64,
   parameter int ROUNDS = 80,
   parameter int UNROLL = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [16*WORD-1:0] in_block,
   input  logic [8*WORD-1:0]  in_hash,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*WORD-1:0]  out_hash,
   output logic               busy
);
   localparam int CW = $clog2(ROUNDS + 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     rnd_q;
   logic [8*WORD-1:0] h_q, wv_q, wv_d, out_hash_q, hash_d;
   logic [WORD-1:0]   w_q [16];
   logic [WORD-1:0]   w_d [16];
   logic [WORD-1:0]   wx  [16+UNROLL];
   logic [WORD-1:0]   kt  [UNROLL];
   logic              last_rnd;

   function automatic logic [WORD-1:0] k_at(input int idx);
      logic [63:0] k;
      k = '0;
      if (WORD == 64) begin
         if (idx < 80) k = K512[idx[6:0]];
      end else if (idx < 64) begin
         k = {32'd0, K256[idx[5:0]]};
      end
      return WORD'(k);
   endfunction

   assign last_rnd  = (rnd_q == CW'(ROUNDS - UNROLL));
   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign out_hash  = out_hash_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last_rnd)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // wx[j] is W(t+j); the words past index 15 extend the window by UNROLL.
   always_comb begin
      for (int i = 0; i < 16; i++) wx[i] = w_q[i];
      for (int j = 0; j < UNROLL; j++) begin
         wx[16+j] = WORD'(sigma(64'(wx[14+j]), WORD, 4'd9, 1'b1)) + wx[9+j]
                  + WORD'(sigma(64'(wx[1+j]), WORD, 4'd6, 1'b1)) + wx[j];
      end
      for (int i = 0; i < 16; i++) w_d[i] = wx[i+UNROLL];
   end

   always_comb begin
      for (int j = 0; j < UNROLL; j++) kt[j] = k_at(int'(rnd_q) + j);
   end

   for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
      logic [8*WORD-1:0] st_in;
      logic [8*WORD-1:0] st_out;
      if (j == 0) begin : g_first
         assign st_in = wv_q;
      end else begin : g_next
         assign st_in = g_rnd[j-1].st_out;
      end
      sha2_round #(.WORD(WORD)) u_round (
         .st_i (st_in),
         .wt_i (wx[j]),
         .kt_i (kt[j]),
         .st_o (st_out)
      );
   end

   assign wv_d = g_rnd[UNROLL-1].st_out;

   always_comb begin
      hash_d = '0;
      for (int i = 0; i < 8; i++) hash_d[i*WORD +: WORD] = h_q[i*WORD +: WORD] + wv_d[i*WORD +: WORD];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rnd_q      <= '0;
         h_q        <= '0;
         wv_q       <= '0;
         out_hash_q <= '0;
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: if (in_valid) begin
               h_q   <= in_hash;
               wv_q  <= in_hash;
               rnd_q <= '0;
               for (int i = 0; i < 16; i++) w_q[i] <= in_block[(15-i)*WORD +: WORD];
            end
            RUN: begin
               wv_q  <= wv_d;
               rnd_q <= rnd_q + CW'(UNROLL);
               for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
               if (last_rnd) out_hash_q <= hash_d;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha2_compress_engine.sv
// Directed bench: SHA-512, SHA-256 and 4x-unrolled SHA-512 engines against known digests.
module tb_sha2_compress_engine;

   localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'd0, 64'h18};
   localparam logic [1023:0] ABC256 = {512'd0, 32'h61626380, 448'd0, 32'h18};
   localparam logic [1023:0] BLK2   = {960'd0, 64'd896};
   localparam logic [511:0]  IV512  = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
                                       64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
                                       64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
   localparam logic [511:0]  IV256  = {256'd0, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
   localparam logic [511:0]  D512   = {64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2,
                                       64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
                                       64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
   localparam logic [511:0]  D256   = {256'd0, 32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                       32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
   localparam logic [511:0]  D896   = {64'h8e959b75dae313da, 64'h8cf4f72814fc143f, 64'h8f7779c6eb9f7fa1,
                                       64'h7299aeadb6889018, 64'h501d289e4900f7e4, 64'h331b99dec4b5433a,
                                       64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

   typedef struct {
      int             sel;
      logic [1023:0]  blk;
      logic [511:0]   hash;
      bit             chain;
      bit             chk;
      logic [511:0]   exp;
      int             lat;
      string          name;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [2:0]    v, r;
   logic [1023:0] blk;
   logic [511:0]  hin;
   logic          ir0, ov0, b0, ir1, ov1, b1, ir2, ov2, b2;
   logic [511:0]  oh0, oh2;
   logic [255:0]  oh1;

   sha2_compress_engine #(.WORD(64), .ROUNDS(80), .UNROLL(1)) u_dut512 (
      .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(ir0), .in_block(blk), .in_hash(hin),
      .out_valid(ov0), .out_ready(r[0]), .out_hash(oh0), .busy(b0));

   sha2_compress_engine #(.WORD(32), .ROUNDS(64), .UNROLL(1)) u_dut256 (
      .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(ir1), .in_block(blk[511:0]), .in_hash(hin[255:0]),
      .out_valid(ov1), .out_ready(r[1]), .out_hash(oh1), .busy(b1));

   sha2_compress_engine #(.WORD(64), .ROUNDS(80), .UNROLL(4)) u_dut512x4 (
      .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(ir2), .in_block(blk), .in_hash(hin),
      .out_valid(ov2), .out_ready(r[2]), .out_hash(oh2), .busy(b2));

   int            sel;
   logic          cir, cov, cb;
   logic [511:0]  coh;

   always_comb begin
      cir = ir0; cov = ov0; cb = b0; coh = oh0;
      case (sel)
         1: begin cir = ir1; cov = ov1; cb = b1; coh = {256'd0, oh1}; end
         2: begin cir = ir2; cov = ov2; cb = b2; coh = oh2; end
         default: ;
      endcase
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int s, input logic [1023:0] b, input logic [511:0] h, input bit ch,
                               input bit ck, input logic [511:0] e, input int l, input string nm);
      vec_t t;
      t.sel = s; t.blk = b; t.hash = h; t.chain = ch; t.chk = ck; t.exp = e; t.lat = l; t.name = nm;
      return t;
   endfunction

   // Offer one block on engine s, return its digest and accept-to-out_valid latency, then handshake.
   task automatic run_block(input int s, input logic [1023:0] b, input logic [511:0] h,
                            output logic [511:0] dig, output int lat);
      int n;
      sel = s; blk = b; hin = h;
      n = 0;
      @(negedge clk);
      while (!cir && n < 300) begin @(negedge clk); n++; end
      v[s] = 1'b1;
      @(negedge clk);
      v[s] = 1'b0;
      n = 0;
      while (!cov && n < 300) begin @(negedge clk); n++; end
      lat = n;
      dig = coh;
      r[s] = 1'b1;
      @(negedge clk);
      r[s] = 1'b0;
      check("handshake out_valid", 512'(cov), 512'(0));
      check("handshake in_ready", 512'(cir), 512'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tv [5];
      logic [1023:0] b1;
      logic [511:0]  dig, prev, snap, h;
      int            lat, n;
      bit            stable;

      rst = 1'b1; v = '0; r = '0; blk = '0; hin = '0; sel = 0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check("reset in_ready", 512'(cir), 512'(1));
         check("reset out_valid", 512'(cov), 512'(0));
         check("reset busy", 512'(cb), 512'(0));
         check("reset out_hash", coh, 512'd0);
      end
      rst = 1'b0;

      b1 = '0;
      for (int i = 0; i < 14; i++)
         for (int k = 0; k < 8; k++) b1[1023 - 64*i - 8*k -: 8] = 8'h61 + 8'(i + k);
      b1[1023 - 64*14 -: 64] = 64'h8000000000000000;

      tv[0] = mk(0, ABC512, IV512, 1'b0, 1'b1, D512, 80, "sha512_abc");
      tv[1] = mk(1, ABC256, IV256, 1'b0, 1'b1, D256, 64, "sha256_abc");
      tv[2] = mk(2, ABC512, IV512, 1'b0, 1'b1, D512, 20, "sha512x4_abc");
      tv[3] = mk(2, b1,     IV512, 1'b0, 1'b0, '0,   20, "sha512x4_blk1");
      tv[4] = mk(2, BLK2,   IV512, 1'b1, 1'b1, D896, 20, "sha512x4_blk2");

      prev = '0;
      for (int i = 0; i < 5; i++) begin
         h = tv[i].chain ? prev : tv[i].hash;
         run_block(tv[i].sel, tv[i].blk, h, dig, lat);
         check({tv[i].name, " latency"}, 512'(lat), 512'(tv[i].lat));
         if (tv[i].chk) check({tv[i].name, " digest"}, dig, tv[i].exp);
         prev = dig;
      end

      // Backpressure in DONE, garbage in_valid pulses must be ignored.
      sel = 0; blk = ABC512; hin = IV512;
      @(negedge clk); v[0] = 1'b1;
      @(negedge clk); v[0] = 1'b0;
      n = 0;
      while (!cov && n < 300) begin @(negedge clk); n++; end
      check("bp latency", 512'(n), 512'(80));
      snap = coh;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         v[0] = (k % 2 == 0);
         blk  = {16{64'hdeadbeefcafef00d}};
         hin  = {8{64'h0123456789abcdef}};
         @(negedge clk);
         if (coh !== snap || cir || !cov || !cb) stable = 1'b0;
      end
      check("bp hold", 512'(stable), 512'(1));
      check("bp digest", coh, D512);

      // Back-to-back: in_valid and out_ready both held high from here.
      blk = ABC512; hin = IV512; v[0] = 1'b1; r[0] = 1'b1;
      @(negedge clk);
      check("bp release ready/valid", 512'({cir, cov}), 512'(2'b10));
      @(negedge clk);
      check("b2b accept busy/ready", 512'({cb, cir}), 512'(2'b10));
      n = 0;
      while (!cov && n < 300) begin @(negedge clk); n++; end
      check("b2b latency", 512'(n), 512'(80));
      check("b2b digest1", coh, D512);
      n = 0;
      do begin @(negedge clk); n++; end while (!cov && n < 300);
      // 80 RUN cycles plus one DONE and one IDLE cycle between completions
      check("b2b completion gap", 512'(n), 512'(82));
      check("b2b digest2", coh, D512);
      v[0] = 1'b0;
      @(negedge clk);
      r[0] = 1'b0;
      @(negedge clk);
      check("b2b idle after", 512'({cir, cov, cb}), 512'(3'b100));

      // Abort at round 37, with out_ready high during RUN having no effect.
      sel = 0; blk = ABC512; hin = IV512;
      @(negedge clk); v[0] = 1'b1;
      @(negedge clk); v[0] = 1'b0; r[0] = 1'b1;
      repeat (37) @(negedge clk);
      check("out_ready in RUN ignored", 512'({cb, cov, cir}), 512'(3'b100));
      r[0] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort in_ready", 512'(cir), 512'(1));
      check("abort out_valid", 512'(cov), 512'(0));
      check("abort busy", 512'(cb), 512'(0));
      check("abort out_hash", coh, 512'd0);
      run_block(0, ABC512, IV512, dig, lat);
      check("after abort latency", 512'(lat), 512'(80));
      check("after abort digest", dig, D512);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
